neuron_mac_sequencer: RTL and testbench
=======================================

// Module: neuron_mac_sequencer
// PURPOSE
//  Downstream consumer of the weight ROM: computes one neuron's dot product over N_INPUTS activations.
//  - Sequences ROM addresses and asserts the ROM enable.
//  - Accepts activations over a valid/ready stream.
//  - Multiplies each activation by its weight and accumulates the products.
//  - Presents the sum on a valid/ready result port.
//  Sits between the weight ROM and the activation/output stage of the network datapath.
// PARAMETERS
//  N_INPUTS   8    activations (and weights) per neuron; >=2
//  DATA_W     8    activation and weight width, unsigned
//  ACC_W      20   accumulator/result width; must be >= 2*DATA_W+clog2(N_INPUTS) (checked at elaboration)
//  NIDX_W     4    neuron index width
//  BASE_ADDR  0    ROM address of weight 0 of neuron 0
// PORTS
//  clk           in   1       single clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  start         in   1       pulse; begins a neuron computation (honoured in IDLE only)
//  neuron_idx    in   NIDX_W  neuron to compute; latched on accepted start
//  in_data       in   DATA_W  activation value
//  in_valid      in   1       in_data is valid
//  in_ready      out  1       block accepts in_data this cycle
//  rom_address   out  8       weight ROM address
//  rom_enable    out  1       weight ROM enable (ROM drives Z when low)
//  rom_data      in   DATA_W  weight read combinationally from the ROM
//  result        out  ACC_W   dot product
//  result_valid  out  1       result is valid
//  result_ready  in   1       downstream accepts result
//  busy          out  1       high in RUN or DONE
// BEHAVIOUR
//  - Reset (async): state=IDLE; k=0; acc=0; result=0; result_valid=0; in_ready=0; rom_enable=0;
//    rom_address=BASE_ADDR; busy=0.
//  - FSM states:
//    - IDLE: start=1 -> RUN; latch n=neuron_idx; k=0; acc=0.
//    - RUN: in_ready=1; rom_enable=1; rom_address=(BASE_ADDR+n*N_INPUTS+k) mod 256.
//      - Beat = in_valid&&in_ready: acc<=acc+in_data*rom_data (unsigned, DATA_W x DATA_W -> 2*DATA_W,
//        zero-extended to ACC_W; no saturation needed given the ACC_W rule); k<=k+1.
//      - Beat with k==N_INPUTS-1: result<=acc+product; result_valid<=1; -> DONE.
//      - in_valid=0: stall; k, acc and rom_address are held.
//    - DONE: result_valid=1; result is stable; in_ready=0; rom_enable=0.
//      result_ready=1 -> IDLE; result_valid<=0 on the next edge.
//  - rom_data is sampled only when rom_enable=1 (the Z bus is never accumulated).
//  - rom_address is registered from k and updates the same edge k advances.
//    The weight used for a beat is therefore the one addressed during that beat.
//  - Latency: result_valid rises on the edge of the N_INPUTS-th beat.
//    Minimum start-to-result is N_INPUTS+1 cycles.
//  - Boundary conditions:
//    - start in RUN or DONE: ignored, no effect.
//    - start in the same cycle as the DONE->IDLE handshake: ignored.
//    - Ports are 8 bits; the ROM holds 128 entries. Integrator guarantees
//      BASE_ADDR+(2^NIDX_W)*N_INPUTS <= 128. Beyond that the address wraps mod 256.
//    - rst mid-RUN or mid-DONE: immediate return to the reset values; the partial sum is discarded.
//    - in_valid while not RUN: not consumed (in_ready=0).
// STRUCTURE
//  - Shared include nn_defs.vh: NN_DATA_W=8, NN_ROM_ADDR_W=8, NN_ROM_DEPTH=128, state encodings
//    (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
//  - Sub-module nn_mac_accumulator (clk, rst, clr, en, a, b, acc): multiply and accumulate.
//  - The sequencer FSM, address counter and handshake logic live in this module.
// TESTING (ROM loaded with 1,3,2,5,6,5,5,2 repeating; N_INPUTS=8)
//  1 neuron_idx=0, eight beats of in_data=1, in_valid held high -> addresses 0..7; result=29;
//    result_valid rises 9 cycles after start.
//  2 neuron_idx=0, in_data=0,1,..,7 -> result=115.
//  3 neuron_idx=3, in_data=255 x8 -> addresses 24..31; result=7395 (no overflow in 20 bits).
//  4 in_valid toggled 1,0,0,1,... during test 2 stimulus -> address held during stalls; result still 115;
//    rom_enable=0 outside RUN.
//  5 result_ready held low 5 cycles in DONE; start pulsed during it -> result 29 held stable;
//    start ignored; IDLE after the handshake.
//  6 rst asserted after 4 beats, then a fresh start with all-1 inputs -> outputs at reset values
//    immediately; next result=29.

Source files
------------

// File: rtl/neuron_mac_sequencer_pkg.sv
// Shared definitions for the neuron MAC sequencer: datapath widths, ROM
// geometry, FSM state encoding and the weight-address helper.
package neuron_mac_sequencer_pkg;

    localparam int NN_DATA_W     = 8;
    localparam int NN_ROM_ADDR_W = 8;
    localparam int NN_ROM_DEPTH  = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ROM address of weight k of neuron n. The result wraps modulo 256.
    function automatic logic [NN_ROM_ADDR_W-1:0] weight_addr(
        input int unsigned base,
        input int unsigned n,
        input int unsigned n_inputs,
        input int unsigned k
    );
        int unsigned full;
        full = base + n * n_inputs + k;
        return full[NN_ROM_ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/neuron_mac_sequencer_if.sv
// Handshake bundle of the neuron MAC sequencer. It carries the start
// command, the activation stream, the weight ROM port and the result stream.
// master = environment (controller, activation source, ROM, result sink)
// slave  = the sequencer
interface neuron_mac_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int NIDX_W = 4
) ();
    import neuron_mac_sequencer_pkg::*;

    logic                     start;
    logic [NIDX_W-1:0]        neuron_idx;
    logic [DATA_W-1:0]        in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic [NN_ROM_ADDR_W-1:0] rom_address;
    logic                     rom_enable;
    logic [DATA_W-1:0]        rom_data;
    logic [ACC_W-1:0]         result;
    logic                     result_valid;
    logic                     result_ready;
    logic                     busy;

    modport master (
        output start, neuron_idx, in_data, in_valid, rom_data, result_ready,
        input  in_ready, rom_address, rom_enable, result, result_valid, busy
    );

    modport slave (
        input  start, neuron_idx, in_data, in_valid, rom_data, result_ready,
        output in_ready, rom_address, rom_enable, result, result_valid, busy
    );

endinterface

// File: rtl/neuron_mac_sequencer_acc.sv
// Unsigned multiply-accumulate. The product is exported so the sequencer
// can form the final sum in the same cycle as the last accumulation.
module nn_mac_accumulator #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   prod,
    output logic [ACC_W-1:0]      acc
);

    // Full-width unsigned product; operands zero-extended so nothing is lost.
    always_comb begin
        prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    end

    // Accumulator: clear has priority over an accumulate beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Neuron MAC sequencer: walks the weight ROM for one neuron, pairs each
// weight with an incoming activation and presents the dot product on a
// valid/ready result port.
module neuron_mac_sequencer
    import neuron_mac_sequencer_pkg::*;
#(
    parameter int N_INPUTS  = 8,
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 20,
    parameter int NIDX_W    = 4,
    parameter int BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    neuron_mac_sequencer_if.slave bus
);

    localparam int K_W = $clog2(N_INPUTS);

    if (N_INPUTS < 2) begin : g_n_inputs_check
        $error("neuron_mac_sequencer: N_INPUTS must be >= 2");
    end
    if (ACC_W < 2 * DATA_W + $clog2(N_INPUTS)) begin : g_acc_w_check
        $error("neuron_mac_sequencer: ACC_W too narrow for N_INPUTS products");
    end

    state_t              state;
    logic [K_W-1:0]      k;
    logic [NIDX_W-1:0]   n;
    logic                beat;
    logic                last_beat;
    logic                acc_clr;
    logic [DATA_W-1:0]   weight;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    acc;

    // Beat qualification and weight gating: a disabled ROM floats its bus,
    // so the weight is forced to zero unless the enable is up.
    always_comb begin
        beat      = (state == RUN) && bus.in_valid && bus.in_ready;
        last_beat = beat && (k == K_W'(N_INPUTS - 1));
        acc_clr   = (state == IDLE) && bus.start;
        weight    = bus.rom_enable ? bus.rom_data : '0;
    end

    nn_mac_accumulator #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_clr),
        .en   (beat),
        .a    (bus.in_data),
        .b    (weight),
        .prod (prod),
        .acc  (acc)
    );

    // Sequencer FSM with registered handshake, ROM and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            k                <= '0;
            n                <= '0;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
            bus.in_ready     <= 1'b0;
            bus.rom_enable   <= 1'b0;
            bus.rom_address  <= weight_addr(BASE_ADDR, 0, N_INPUTS, 0);
            bus.busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state           <= RUN;
                        n               <= bus.neuron_idx;
                        k               <= '0;
                        bus.rom_address <= weight_addr(BASE_ADDR, 32'(bus.neuron_idx), N_INPUTS, 0);
                        bus.in_ready    <= 1'b1;
                        bus.rom_enable  <= 1'b1;
                        bus.busy        <= 1'b1;
                    end
                end
                RUN: begin
                    if (beat) begin
                        k <= k + 1'b1;
                        if (last_beat) begin
                            state            <= DONE;
                            bus.result       <= acc + ACC_W'(prod);
                            bus.result_valid <= 1'b1;
                            bus.in_ready     <= 1'b0;
                            bus.rom_enable   <= 1'b0;
                        end else begin
                            bus.rom_address <= weight_addr(BASE_ADDR, 32'(n), N_INPUTS, 32'(k) + 1);
                        end
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        state            <= IDLE;
                        bus.result_valid <= 1'b0;
                        bus.busy         <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Scoreboard bench for neuron_mac_sequencer with a weight ROM model
// holding 1,3,2,5,6,5,5,2 repeating.
module tb_neuron_mac_sequencer;
    import neuron_mac_sequencer_pkg::*;

    localparam int N_INPUTS = 8;
    localparam int DATA_W   = 8;
    localparam int ACC_W    = 20;
    localparam int NIDX_W   = 4;

    logic clk;
    logic rst;

    neuron_mac_sequencer_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .NIDX_W(NIDX_W)) bus ();

    neuron_mac_sequencer #(
        .N_INPUTS  (N_INPUTS),
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .NIDX_W    (NIDX_W),
        .BASE_ADDR (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] rom_mem [128];
    logic [7:0] pat [8];

    assign bus.rom_data = bus.rom_enable ? rom_mem[bus.rom_address[6:0]] : 8'hxx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rv_rise_cyc = 0;
    logic rv_prev = 1'b0;
    int exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every result handshake.
    always @(negedge clk) begin
        if (bus.result_valid && !rv_prev) rv_rise_cyc = cyc;
        rv_prev = bus.result_valid;
        if (bus.result_valid && bus.result_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", int'(bus.result), -1);
            end else begin
                chk("result", int'(bus.result), exp_q.pop_front());
            end
        end
    end

    task automatic start_neuron(input int n, input int expv, input bit push);
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.neuron_idx = NIDX_W'(n);
        start_cyc      = cyc;
        if (push) exp_q.push_back(expv);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic do_beat(input int d, input int addr, input int nstall);
        int t;
        bus.in_valid = 1'b0;
        for (int s = 0; s < nstall; s++) begin
            @(negedge clk);
            chk("stall_addr", int'(bus.rom_address), addr);
            chk("stall_in_ready", int'(bus.in_ready), 1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = DATA_W'(d);
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_wait", int'(bus.in_ready), 1);
        chk("beat_addr", int'(bus.rom_address), addr);
        chk("beat_rom_enable", int'(bus.rom_enable), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_neuron(input int n, input int d [8], input int nstall);
        for (int k = 0; k < N_INPUTS; k++)
            do_beat(d[k], n * N_INPUTS + k, (k == 0) ? 0 : nstall);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (bus.busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("idle_reached", int'(bus.busy), 0);
        chk("idle_rom_enable", int'(bus.rom_enable), 0);
        chk("idle_in_ready", int'(bus.in_ready), 0);
    endtask

    task automatic wait_rv();
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.result_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("result_valid_wait", int'(bus.result_valid), 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_result"}, int'(bus.result), 0);
        chk({tag, "_result_valid"}, int'(bus.result_valid), 0);
        chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
        chk({tag, "_rom_enable"}, int'(bus.rom_enable), 0);
        chk({tag, "_rom_address"}, int'(bus.rom_address), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones [8];
        int ramp [8];
        int full [8];
        pat = '{8'd1, 8'd3, 8'd2, 8'd5, 8'd6, 8'd5, 8'd5, 8'd2};
        for (int i = 0; i < 128; i++) rom_mem[i] = pat[i % 8];
        for (int i = 0; i < 8; i++) begin
            ones[i] = 1;
            ramp[i] = i;
            full[i] = 255;
        end

        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.neuron_idx   = '0;
        bus.in_data      = '0;
        bus.in_valid     = 1'b0;
        bus.result_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: all-ones activations, back-to-back beats, latency check
        start_neuron(0, 29, 1'b1);
        run_neuron(0, ones, 0);
        wait_idle();
        chk("latency", rv_rise_cyc - start_cyc, 9);

        // 2: ramp activations
        start_neuron(0, 115, 1'b1);
        run_neuron(0, ramp, 0);
        wait_idle();

        // 3: neuron 3, full-scale activations
        start_neuron(3, 7395, 1'b1);
        run_neuron(3, full, 0);
        wait_idle();

        // 4: ramp activations with two stall cycles before each later beat
        start_neuron(0, 115, 1'b1);
        run_neuron(0, ramp, 2);
        wait_idle();

        // 5: back-pressure in DONE, start pulses ignored
        bus.result_ready = 1'b0;
        start_neuron(0, 29, 1'b1);
        run_neuron(0, ones, 0);
        wait_rv();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_result", int'(bus.result), 29);
            chk("hold_valid", int'(bus.result_valid), 1);
            chk("hold_busy", int'(bus.busy), 1);
            @(posedge clk); #1;
            bus.start      = (i == 2);
            bus.neuron_idx = 4'd5;
        end
        bus.result_ready = 1'b1;
        bus.start        = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("post_hs_busy", int'(bus.busy), 0);
        chk("post_hs_valid", int'(bus.result_valid), 0);
        @(negedge clk);
        chk("start_ignored_busy", int'(bus.busy), 0);
        chk("start_ignored_in_ready", int'(bus.in_ready), 0);

        // 6: reset after four beats, then a fresh run
        start_neuron(0, 0, 1'b0);
        for (int k = 0; k < 4; k++) do_beat(1, k, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals("midrun_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        start_neuron(0, 29, 1'b1);
        run_neuron(0, ones, 0);
        wait_idle();

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
